cic_decim_rt: RTL and testbench

//  N-stage CIC decimator with a runtime-programmable decimation rate, differential delay 1 or 2,

---
 rtl/cic_pkg.sv | 21 ++
 rtl/cic_decim_rt_comb.sv | 30 +++
 rtl/cic_decim_rt.sv | 127 ++++++++++++
 tb/tb_cic_decim_rt.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared defaults and elaboration-time helpers for the runtime-rate CIC decimator.
package cic_pkg;

  localparam int CIC_SECTIONS_DEF   = 3;
  localparam int CIC_MAX_RATE_DEF   = 64;
  localparam int CIC_DIFF_DELAY_DEF = 1;
  localparam int CIC_INPUT_W_DEF    = 12;
  localparam int CIC_OUTPUT_W_DEF   = 18;

  // Hogenauer full-precision width: input plus N*log2(R*M) bits of growth.
  function automatic int cic_acc_w(input int in_w, input int n, input int r, input int m);
    return in_w + n * $clog2(r * m);
  endfunction

  function automatic int cic_rate_clamp(input int rate, input int max_rate);
    if (rate <= 0) return 1;
    if (rate > max_rate) return max_rate;
    return rate;
  endfunction

endpackage

// File: rtl/cic_decim_rt_comb.sv
// One CIC comb section: y = x - x[-M]; the delay line advances only on a decimated load.
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int WIDTH = cic_acc_w(CIC_INPUT_W_DEF, CIC_SECTIONS_DEF, CIC_MAX_RATE_DEF,
                                  CIC_DIFF_DELAY_DEF),
  parameter int DEPTH = CIC_DIFF_DELAY_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_load,
  input  logic signed [WIDTH-1:0] i_data,
  output logic signed [WIDTH-1:0] o_data
);

  logic signed [WIDTH-1:0] r_dly [DEPTH];

  // NOTE: the delay line is only M words deep, so it is cleared with the rest of the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_dly[i] <= '0;
    end else if (i_load) begin
      r_dly[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  assign o_data = i_data - r_dly[DEPTH-1];

endmodule

// File: rtl/cic_decim_rt.sv
// Runtime-rate CIC decimator with valid/ready on both sides.
// Optional macro CIC_ROUND_EN: round-half-up and saturate at the output truncation point.
module cic_decim_rt
  import cic_pkg::*;
#(
  parameter int  SECTIONS     = CIC_SECTIONS_DEF,
  parameter int  MAX_RATE     = CIC_MAX_RATE_DEF,
  parameter int  DIFF_DELAY   = CIC_DIFF_DELAY_DEF,
  parameter int  INPUT_WIDTH  = CIC_INPUT_W_DEF,
  parameter int  OUTPUT_WIDTH = CIC_OUTPUT_W_DEF,
  localparam int ACC_W        = cic_acc_w(INPUT_WIDTH, SECTIONS, MAX_RATE, DIFF_DELAY),
  localparam int RATE_W       = $clog2(MAX_RATE) + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic        [RATE_W-1:0]       rate,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [INPUT_WIDTH-1:0]  in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [OUTPUT_WIDTH-1:0] out_data
);

  localparam int SHIFT = ACC_W - OUTPUT_WIDTH;

  logic signed [ACC_W-1:0]        r_integ [SECTIONS];
  logic signed [ACC_W-1:0]        w_comb  [SECTIONS+1];
  logic        [RATE_W-1:0]       r_cnt, r_rate, w_rate, w_rate_in;
  logic                           r_rate_ok, r_dec_pend, r_out_valid;
  logic signed [OUTPUT_WIDTH-1:0] r_out_data, w_scaled;
  logic                           w_accept, w_wrap, w_load;

  assign w_rate_in = RATE_W'(cic_rate_clamp(int'(rate), MAX_RATE));
  // Until the first clock after reset the live clamped rate stands in for the latched one.
  assign w_rate    = r_rate_ok ? r_rate : w_rate_in;
  assign w_load    = r_dec_pend && (!r_out_valid || out_ready);
  assign in_ready  = !(r_dec_pend && r_out_valid && !out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_wrap    = w_accept && (r_cnt == w_rate - RATE_W'(1));

  // NOTE: sequential state uses non-blocking assignments so each stage reads pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SECTIONS; i++) r_integ[i] <= '0;
    end else if (w_accept) begin
      r_integ[0] <= r_integ[0] + ACC_W'(in_data);
      for (int i = 1; i < SECTIONS; i++) r_integ[i] <= r_integ[i] + r_integ[i-1];
    end
  end

  assign w_comb[0] = r_integ[SECTIONS-1];

  for (genvar g = 0; g < SECTIONS; g++) begin : g_comb
    cic_comb_stage #(.WIDTH(ACC_W), .DEPTH(DIFF_DELAY)) u_comb (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_load),
      .i_data (w_comb[g]),
      .o_data (w_comb[g+1])
    );
  end

`ifdef CIC_ROUND_EN
  if (SHIFT > 0) begin : g_round
    logic signed [ACC_W:0]        w_sum;
    logic signed [OUTPUT_WIDTH:0] w_rnd;
    logic                         w_unused_lsb;
    assign w_sum        = {w_comb[SECTIONS][ACC_W-1], w_comb[SECTIONS]}
                        + ((ACC_W+1)'(1) << (SHIFT - 1));
    assign w_rnd        = w_sum[ACC_W -: OUTPUT_WIDTH+1];
    assign w_unused_lsb = ^w_sum[SHIFT-1:0];
    // NOTE: default assigned first so the saturation mux never infers a latch.
    always_comb begin
      w_scaled = w_rnd[OUTPUT_WIDTH-1:0];
      if (w_rnd[OUTPUT_WIDTH] != w_rnd[OUTPUT_WIDTH-1])
        w_scaled = w_rnd[OUTPUT_WIDTH] ? {1'b1, {(OUTPUT_WIDTH-1){1'b0}}}
                                       : {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
    end
  end else begin : g_pass
    assign w_scaled = w_comb[SECTIONS];
  end
`else
  assign w_scaled = w_comb[SECTIONS][ACC_W-1 -: OUTPUT_WIDTH];
  if (SHIFT > 0) begin : g_trunc
    logic w_unused_lsb;
    assign w_unused_lsb = ^w_comb[SECTIONS][SHIFT-1:0];
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_rate      <= RATE_W'(1);
      r_rate_ok   <= 1'b0;
      r_dec_pend  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (!r_rate_ok) begin
        r_rate    <= w_rate_in;
        r_rate_ok <= 1'b1;
      end
      if (w_accept) begin
        if (w_wrap) begin
          r_cnt  <= '0;
          r_rate <= w_rate_in;
        end else begin
          r_cnt <= r_cnt + RATE_W'(1);
        end
      end
      // A wrap on the load edge (R=1) starts a new pending frame immediately.
      if (w_wrap)      r_dec_pend <= 1'b1;
      else if (w_load) r_dec_pend <= 1'b0;
      if (w_load) begin
        r_out_data  <= w_scaled;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_cic_decim_rt.sv
// Scoreboard bench for cic_decim_rt (N=3, MAX_RATE=8, M=1, 12-bit in, 18-bit out).
module tb_cic_decim_rt;

  localparam int SECTIONS     = 3;
  localparam int MAX_RATE     = 8;
  localparam int DIFF_DELAY   = 1;
  localparam int INPUT_WIDTH  = 12;
  localparam int OUTPUT_WIDTH = 18;
  localparam int RATE_W       = $clog2(MAX_RATE) + 1;

  logic                           clk = 1'b0;
  logic                           reset;
  logic        [RATE_W-1:0]       rate;
  logic                           in_valid;
  logic                           in_ready;
  logic signed [INPUT_WIDTH-1:0]  in_data;
  logic                           out_valid;
  logic                           out_ready;
  logic signed [OUTPUT_WIDTH-1:0] out_data;

  always #5 clk = ~clk;

  cic_decim_rt #(
    .SECTIONS(SECTIONS), .MAX_RATE(MAX_RATE), .DIFF_DELAY(DIFF_DELAY),
    .INPUT_WIDTH(INPUT_WIDTH), .OUTPUT_WIDTH(OUTPUT_WIDTH)
  ) dut (
    .clk(clk), .reset(reset), .rate(rate),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  typedef struct {
    bit                             care;
    logic signed [OUTPUT_WIDTH-1:0] val;
  } exp_t;

  exp_t                           sb_q[$];
  logic signed [OUTPUT_WIDTH-1:0] preset_q[$];
  exp_t                           mon_e;
  int  n_checks = 0, n_pass = 0, n_outs = 0, n_acc = 0;
  int  m_cnt = 0, m_rate = 1, skip = 0, lat_cd = 0;
  bit  m_loaded = 0, lat_en = 0;
  logic signed [OUTPUT_WIDTH-1:0] exp_val = '0;

`ifdef CIC_ROUND_EN
  localparam logic signed [OUTPUT_WIDTH-1:0] DC4_R1 = 1;
`else
  localparam logic signed [OUTPUT_WIDTH-1:0] DC4_R1 = 0;
`endif

  function automatic int clamp_rate(input int r);
    if (r == 0) return 1;
    if (r > MAX_RATE) return MAX_RATE;
    return r;
  endfunction

  // Frame model and scoreboard; handshakes are judged at the negedge before the edge that takes them.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
      m_cnt    = 0;
      m_loaded = 0;
      lat_cd   = 0;
    end else begin
      if (!m_loaded) begin
        m_rate   = clamp_rate(int'(rate));
        m_loaded = 1;
      end
      if (lat_cd > 0) begin
        lat_cd--;
        if (lat_cd == 0 && lat_en) begin
          n_checks++;
          if (out_valid !== 1'b1) $display("FAIL latency out_valid got=%b exp=1", out_valid);
          else n_pass++;
        end
      end
      if (out_valid && out_ready) begin
        n_outs++;
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output got=%0d exp=none", out_data);
        end else begin
          mon_e = sb_q.pop_front();
          if (mon_e.care) begin
            n_checks++;
            if (out_data !== mon_e.val)
              $display("FAIL out_data got=%0d exp=%0d", out_data, mon_e.val);
            else n_pass++;
          end
        end
      end
      if (in_valid && in_ready) begin
        n_acc++;
        m_cnt++;
        if (m_cnt == m_rate) begin
          m_cnt  = 0;
          m_rate = clamp_rate(int'(rate));
          lat_cd = 2;
          if (preset_q.size() > 0) sb_q.push_back('{1'b1, preset_q.pop_front()});
          else if (skip > 0) begin
            sb_q.push_back('{1'b0, '0});
            skip--;
          end else sb_q.push_back('{1'b1, exp_val});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int r);
    rate     = RATE_W'(r);
    in_valid = 1'b0;
    in_data  = '0;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input int d, output int cycles);
    int sent = 0;
    cycles   = 0;
    in_valid = 1'b1;
    in_data  = INPUT_WIDTH'(d);
    while (sent < n && cycles < n + 200) begin
      @(negedge clk);
      if (in_ready) sent++;
      @(posedge clk);
      #1;
      cycles++;
    end
    in_valid = 1'b0;
    if (sent < n) begin
      n_checks++;
      $display("FAIL send_timeout got=%0d exp=%0d", sent, n);
    end
  endtask

  task automatic check_drained(input string name, input int outs0, input int exp_outs);
    idle(6);
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL %s_pending got=%0d exp=0", name, sb_q.size());
    else n_pass++;
    n_checks++;
    if (n_outs - outs0 != exp_outs)
      $display("FAIL %s_outputs got=%0d exp=%0d", name, n_outs - outs0, exp_outs);
    else n_pass++;
  endtask

  task automatic test_reset();
    rate = RATE_W'(8); in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    reset = 1'b1;
    #12;
    n_checks += 3;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else n_pass++;
    if (out_data !== '0) $display("FAIL rst_out_data got=%0d exp=0", out_data); else n_pass++;
    if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", in_ready); else n_pass++;
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks += 2;
    if (out_valid !== 1'b0) $display("FAIL post_rst_out_valid got=%b exp=0", out_valid); else n_pass++;
    if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); else n_pass++;
  endtask

  task automatic test_dc_rate8();
    int cyc, o0;
    do_reset(8);
    skip = 3; exp_val = 6400; lat_en = 1;
    o0 = n_outs;
    send(64, 100, cyc);
    check_drained("dc_rate8", o0, 8);
    lat_en = 0;
  endtask

  task automatic test_rate_switch();
    int cyc, o0;
    do_reset(8);
    skip = 3; exp_val = 6400;
    send(35, 100, cyc);
    rate = RATE_W'(4);
    o0 = n_outs;
    send(5, 100, cyc);
    skip = 2; exp_val = 800;
    send(24, 100, cyc);
    check_drained("rate_switch", o0, 7);
  endtask

  task automatic test_wrap();
    int cyc, o0;
    do_reset(8);
    skip = 3; exp_val = OUTPUT_WIDTH'(-131072);
    o0 = n_outs;
    send(10000, -2048, cyc);
    check_drained("wrap", o0, 1250);
  endtask

  task automatic test_backpressure();
    int acc0, o0;
    bit seen = 0, moved = 0;
    logic signed [OUTPUT_WIDTH-1:0] held = '0;
    do_reset(2);
    out_ready = 1'b0;
    preset_q.push_back(0);
    preset_q.push_back(50);
    acc0 = n_acc; o0 = n_outs;
    in_valid = 1'b1; in_data = INPUT_WIDTH'(100);
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        if (!seen) begin held = out_data; seen = 1; end
        else if (out_data !== held) moved = 1;
      end
    end
    n_checks += 5;
    if (!seen || moved) $display("FAIL bp_held_stable got=%b exp=1", seen && !moved); else n_pass++;
    if (out_valid !== 1'b1) $display("FAIL bp_out_valid got=%b exp=1", out_valid); else n_pass++;
    if (out_data !== 0) $display("FAIL bp_first_data got=%0d exp=0", out_data); else n_pass++;
    if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b exp=0", in_ready); else n_pass++;
    if (n_acc - acc0 != 4) $display("FAIL bp_accepted got=%0d exp=4", n_acc - acc0); else n_pass++;
    in_valid = 1'b0;
    out_ready = 1'b1;
    check_drained("backpressure", o0, 2);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL bp_release_valid got=%b exp=0", out_valid); else n_pass++;
  endtask

  task automatic test_rate_one();
    int cyc, o0;
    do_reset(1);
    skip = 3; exp_val = DC4_R1;
    o0 = n_outs;
    send(20, 4, cyc);
    n_checks++;
    if (cyc != 20) $display("FAIL r1_throughput got=%0d exp=20", cyc); else n_pass++;
    rate = '0;
    send(20, 4, cyc);
    n_checks++;
    if (cyc != 20) $display("FAIL r0_throughput got=%0d exp=20", cyc); else n_pass++;
    check_drained("rate_one", o0, 40);
  endtask

  task automatic test_rate_clamp();
    int cyc, o0;
    do_reset(15);
    skip = 3; exp_val = 6400;
    o0 = n_outs;
    send(48, 100, cyc);
    check_drained("rate_clamp", o0, 6);
  endtask

  task automatic test_reset_midframe();
    int cyc, o0;
    do_reset(8);
    skip = 3; exp_val = 6400;
    send(32, 100, cyc);
    idle(3);
    send(3, 100, cyc);
    #3 reset = 1'b1;
    #1;
    n_checks += 3;
    if (out_valid !== 1'b0) $display("FAIL mid_rst_valid got=%b exp=0", out_valid); else n_pass++;
    if (out_data !== '0) $display("FAIL mid_rst_data got=%0d exp=0", out_data); else n_pass++;
    if (in_ready !== 1'b1) $display("FAIL mid_rst_ready got=%b exp=1", in_ready); else n_pass++;
    do_reset(8);
    skip = 3;
    o0 = n_outs;
    send(7, 100, cyc);
    idle(3);
    n_checks += 2;
    if (out_valid !== 1'b0) $display("FAIL early_out_valid got=%b exp=0", out_valid); else n_pass++;
    if (n_outs != o0) $display("FAIL early_outputs got=%0d exp=0", n_outs - o0); else n_pass++;
    send(1, 100, cyc);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL eighth_latency_early got=%b exp=0", out_valid); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL eighth_out_valid got=%b exp=1", out_valid); else n_pass++;
    check_drained("reset_midframe", o0, 1);
  endtask

  initial begin
    test_reset();
    test_dc_rate8();
    test_rate_switch();
    test_wrap();
    test_backpressure();
    test_rate_one();
    test_rate_clamp();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
